// File: rtl/hl_eth_pkg.sv
// Shared Hermes Lite Ethernet definitions: receive FSM states, CRC-32 constants
// and MII preamble/SFD nibble values.
package hl_eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

endpackage

// File: rtl/mii_rx_deframer_if.sv
// Byte stream and end-of-frame status from the MII deframer to the packet parser.
interface mii_rx_deframer_if;

  // rx_valid qualifies rx_data and rx_sop for exactly one cycle; there is no
  // ready, so the consumer must take every strobe. rx_eop qualifies the status
  // fields (rx_crc_ok, rx_len_err, rx_len), which then hold until the next rx_eop.
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_crc_ok;
  logic        rx_len_err;
  logic [10:0] rx_len;
  logic        rx_active;

  modport master (
    output rx_data, rx_valid, rx_sop, rx_eop,
    output rx_crc_ok, rx_len_err, rx_len, rx_active
  );

  modport slave (
    input rx_data, rx_valid, rx_sop, rx_eop,
    input rx_crc_ok, rx_len_err, rx_len, rx_active
  );

endinterface

// File: rtl/crc32_nib.sv
// Combinational CRC-32 step (reflected 0xEDB88320) consuming one nibble LSB first.
module crc32_nib
  import hl_eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nib,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) c = (c >> 1) ^ CRC32_POLY;
      else               c = c >> 1;
    end
    crc_next = c;
  end

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes (low
// nibble first), checks FCS residue and frame length, reports status at rx_eop.
module mii_rx_deframer
  import hl_eth_pkg::*;
#(
  parameter int MAX_LEN = 1522,
  parameter int MIN_LEN = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                PHY_RX,
  input  logic                      RX_DV,
  mii_rx_deframer_if.master         rx,
  output rx_state_t                 state_dbg
);

  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] CNT_SAT = 11'h7FF;

  rx_state_t   state_q, state_d;
  logic        phase_q, phase_d;     // 1 = next nibble is the high half of a byte
  logic [3:0]  low_q, low_d;
  logic [31:0] crc_q, crc_d, crc_step;
  logic [10:0] cnt_q, cnt_d;
  logic        over_q, over_d;

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        crc_ok_q, crc_ok_d;
  logic        len_err_q, len_err_d;
  logic [10:0] len_q, len_d;
  logic        active_q, active_d;

  crc32_nib u_crc (
    .crc      (crc_q),
    .nib      (PHY_RX),
    .crc_next (crc_step)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    low_d     = low_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    over_d    = over_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    crc_ok_d  = crc_ok_q;
    len_err_d = len_err_q;
    len_d     = len_q;

    case (state_q)
      ST_IDLE: begin
        if (RX_DV) state_d = (PHY_RX == PRE_NIB) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!RX_DV) begin
          state_d = ST_IDLE;
        end else if (PHY_RX == SFD_NIB) begin
          state_d = ST_DATA;
          crc_d   = CRC32_INIT;
          phase_d = 1'b0;
          cnt_d   = 11'd0;
          over_d  = 1'b0;
        end else if (PHY_RX != PRE_NIB) begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!RX_DV) begin
          // A pending low nibble (odd count) means a dribble frame: never good.
          state_d   = ST_IDLE;
          eop_d     = 1'b1;
          len_d     = cnt_q;
          crc_ok_d  = (crc_q == CRC32_RESIDUE) && !phase_q;
          len_err_d = over_q || (cnt_q < MIN_L) || (cnt_q > MAX_L);
        end else begin
          crc_d   = crc_step;
          phase_d = ~phase_q;
          if (!phase_q) begin
            low_d = PHY_RX;
          end else begin
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 11'd1;
            if (cnt_q < MAX_L) begin
              valid_d = 1'b1;
              data_d  = {PHY_RX, low_q};
              sop_d   = (cnt_q == 11'd0);
            end else begin
              over_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (!RX_DV) state_d = ST_IDLE;
      end
    endcase

    active_d = (state_d == ST_PREAMBLE) || (state_d == ST_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_DROP;
      phase_q   <= 1'b0;
      low_q     <= 4'h0;
      crc_q     <= CRC32_INIT;
      cnt_q     <= 11'd0;
      over_q    <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      crc_ok_q  <= 1'b0;
      len_err_q <= 1'b0;
      len_q     <= 11'd0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      low_q     <= low_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      over_q    <= over_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      crc_ok_q  <= crc_ok_d;
      len_err_q <= len_err_d;
      len_q     <= len_d;
      active_q  <= active_d;
    end
  end

  assign rx.rx_data    = data_q;
  assign rx.rx_valid   = valid_q;
  assign rx.rx_sop     = sop_q;
  assign rx.rx_eop     = eop_q;
  assign rx.rx_crc_ok  = crc_ok_q;
  assign rx.rx_len_err = len_err_q;
  assign rx.rx_len     = len_q;
  assign rx.rx_active  = active_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Directed and randomized frames for mii_rx_deframer, checked against a
// byte-level Ethernet frame model and expected-value queues.
module tb_mii_rx_deframer;
  import hl_eth_pkg::*;

  localparam int MAX_LEN = 1522;
  localparam int MIN_LEN = 64;

  typedef logic [7:0] byte_q_t[$];

  logic       clk;
  logic       rst_n;
  logic [3:0] PHY_RX;
  logic       RX_DV;
  rx_state_t  state_dbg;

  mii_rx_deframer_if m_if ();

  mii_rx_deframer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PHY_RX    (PHY_RX),
    .RX_DV     (RX_DV),
    .rx        (m_if.master),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {sop, data} per expected byte; {crc_ok, len_err, len} per expected eop
  logic [8:0]  exp_q[$];
  logic [12:0] exp_stat[$];

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc32_bytes(input byte_q_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic byte_q_t add_fcs(input byte_q_t p);
    byte_q_t     f;
    logic [31:0] fcs;
    f   = p;
    fcs = crc32_bytes(p, p.size());
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    return f;
  endfunction

  task automatic expect_frame(input byte_q_t fr, input bit dribble);
    int          n;
    bit          ok;
    bit          err;
    logic [10:0] len;
    logic [31:0] fcs_rx;
    n = fr.size();
    for (int i = 0; i < n && i < MAX_LEN; i++) exp_q.push_back({(i == 0), fr[i]});
    ok = 1'b0;
    if (!dribble && n >= 4) begin
      fcs_rx = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
      ok = (crc32_bytes(fr, n - 4) == fcs_rx);
    end
    err = (n < MIN_LEN) || (n > MAX_LEN);
    len = (n > 2047) ? 11'd2047 : 11'(n);
    exp_stat.push_back({ok, err, len});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic dv, input logic [3:0] nib);
    RX_DV  = dv;
    PHY_RX = nib;
    @(posedge clk);
    #1;
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 15; i++) drive(1'b1, PRE_NIB);
    checks++;
    assert (m_if.rx_active === 1'b1) else begin
      errors++; $error("FAIL active_preamble: got %0b expected 1", m_if.rx_active);
    end
    drive(1'b1, SFD_NIB);
  endtask

  task automatic send_frame(input byte_q_t fr, input bit dribble, input int gap);
    expect_frame(fr, dribble);
    send_preamble();
    foreach (fr[i]) begin
      drive(1'b1, fr[i][3:0]);
      drive(1'b1, fr[i][7:4]);
    end
    if (dribble) drive(1'b1, 4'($urandom_range(0, 15)));
    for (int i = 0; i < gap; i++) drive(1'b0, 4'h0);
  endtask

  task automatic check_outputs_clear(input string tag);
    checks++;
    assert ({m_if.rx_valid, m_if.rx_sop, m_if.rx_eop, m_if.rx_active} === 4'b0) else begin
      errors++; $error("FAIL %s_strobes: got %b expected 0000", tag,
                       {m_if.rx_valid, m_if.rx_sop, m_if.rx_eop, m_if.rx_active});
    end
    checks++;
    assert ({m_if.rx_crc_ok, m_if.rx_len_err, m_if.rx_len, m_if.rx_data} === 21'h0) else begin
      errors++; $error("FAIL %s_status: got ok=%0b err=%0b len=%0d data=%02h expected all 0", tag,
                       m_if.rx_crc_ok, m_if.rx_len_err, m_if.rx_len, m_if.rx_data);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [8:0]  e;
    logic [12:0] s;
    if (m_if.rx_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++; $error("FAIL unexpected_byte: got %02h expected no strobe", m_if.rx_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({m_if.rx_sop, m_if.rx_data} === e) else begin
          errors++; $error("FAIL byte: got sop=%0b data=%02h expected sop=%0b data=%02h",
                           m_if.rx_sop, m_if.rx_data, e[8], e[7:0]);
        end
      end
    end else begin
      checks++;
      assert (m_if.rx_sop === 1'b0) else begin
        errors++; $error("FAIL sop_alone: got 1 expected 0");
      end
    end
    if (m_if.rx_eop) begin
      checks++;
      assert (m_if.rx_valid === 1'b0) else begin
        errors++; $error("FAIL eop_with_valid: got 1 expected 0");
      end
      checks++;
      assert (exp_stat.size() > 0) else begin
        errors++; $error("FAIL unexpected_eop: got eop expected none");
      end
      if (exp_stat.size() > 0) begin
        s = exp_stat.pop_front();
        checks++;
        assert ({m_if.rx_crc_ok, m_if.rx_len_err, m_if.rx_len} === s) else begin
          errors++; $error("FAIL status: got ok=%0b err=%0b len=%0d expected ok=%0b err=%0b len=%0d",
                           m_if.rx_crc_ok, m_if.rx_len_err, m_if.rx_len, s[12], s[11], s[10:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    byte_q_t pay;
    byte_q_t fr;
    byte_q_t bad;
    int      n;
    int      mode;

    rst_n  = 1'b0;
    RX_DV  = 1'b0;
    PHY_RX = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_clear("reset");
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 4'h0);

    // minimum good frame: 60 payload bytes 0x00..0x3B + FCS
    pay = {};
    for (int i = 0; i < 60; i++) pay.push_back(8'(i));
    fr = add_fcs(pay);
    send_frame(fr, 1'b0, 3);

    // same frame with payload byte 10 corrupted
    bad = fr;
    bad[10] = bad[10] ^ 8'h40;
    send_frame(bad, 1'b0, 3);

    // good frame plus a dribble nibble
    send_frame(fr, 1'b1, 3);

    // oversize: 1526 payload + FCS = 1530 bytes
    pay = {};
    for (int i = 0; i < 1526; i++) pay.push_back(8'($urandom_range(0, 255)));
    send_frame(add_fcs(pay), 1'b0, 3);

    // RX_DV drops right after the SFD
    fr = {};
    send_frame(fr, 1'b0, 2);

    // broken preamble 0x55 0x57 ... is dropped; good frame follows after 1 idle cycle
    drive(1'b1, 4'h5); drive(1'b1, 4'h5); drive(1'b1, 4'h7); drive(1'b1, 4'h5);
    for (int i = 0; i < 40; i++) drive(1'b1, 4'($urandom_range(0, 15)));
    checks++;
    assert (m_if.rx_active === 1'b0) else begin
      errors++; $error("FAIL active_drop: got %0b expected 0", m_if.rx_active);
    end
    drive(1'b0, 4'h0);
    pay = {};
    for (int i = 0; i < 70; i++) pay.push_back(8'($urandom_range(0, 255)));
    send_frame(add_fcs(pay), 1'b0, 1);
    // back-to-back again with a single idle cycle
    send_frame(add_fcs(pay), 1'b0, 3);

    // asynchronous reset after byte 29 while the low nibble of byte 30 is in
    pay = {};
    for (int i = 0; i < 60; i++) pay.push_back(8'($urandom_range(0, 255)));
    fr = add_fcs(pay);
    for (int i = 0; i < 30; i++) exp_q.push_back({(i == 0), fr[i]});
    send_preamble();
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, fr[i][3:0]);
      drive(1'b1, fr[i][7:4]);
    end
    drive(1'b1, fr[30][3:0]);
    rst_n = 1'b0;
    #1;
    check_outputs_clear("async_reset");
    #2;
    rst_n = 1'b1;
    drive(1'b1, fr[30][7:4]);
    for (int i = 31; i < fr.size(); i++) begin
      drive(1'b1, fr[i][3:0]);
      drive(1'b1, fr[i][7:4]);
    end
    check_outputs_clear("after_reset_frame");
    drive(1'b0, 4'h0);
    drive(1'b0, 4'h0);
    send_frame(add_fcs(pay), 1'b0, 3);

    // randomized frames: good, corrupted or dribbling, varied lengths
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(0, 100);
      pay = {};
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
      fr = add_fcs(pay);
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        n = $urandom_range(0, fr.size() - 1);
        fr[n] = fr[n] ^ 8'(1 << $urandom_range(0, 7));
      end
      send_frame(fr, (mode == 2), $urandom_range(1, 4));
    end

    repeat (6) drive(1'b0, 4'h0);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL bytes_missing: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    assert (exp_stat.size() == 0) else begin
      errors++; $error("FAIL eop_missing: got %0d pending expected 0", exp_stat.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
